banked_regfile_sb: RTL and testbench

Parametrised multi-bank register file with an integrated register scoreboard. It generalises the integer/floating-point register file to N banks of configurable width and depth. Per-register busy bits track in-flight writes from multicycle units and generate a stall for RAW and WAW hazards. It sits between decode (read/issue side) and write-back in the single-cycle/multicycle datapath.

---
 rtl/banked_regfile_sb_if.sv | 34 +++
 rtl/banked_regfile_sb.sv | 89 ++++++++
 tb/tb_banked_regfile_sb.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/banked_regfile_sb_if.sv
// Decode/write-back bundle of the banked register file with scoreboard.
// The master modport is decode/write-back; the slave modport is the register file.
interface banked_regfile_sb_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int BANK_W = 1
);
   logic              write;
   logic [BANK_W-1:0] wbank;
   logic [ADDR_W-1:0] rd;
   logic [WIDTH-1:0]  busW;
   logic [BANK_W-1:0] rbank_a;
   logic [ADDR_W-1:0] rs;
   logic [BANK_W-1:0] rbank_b;
   logic [ADDR_W-1:0] rt;
   logic [WIDTH-1:0]  busA;
   logic [WIDTH-1:0]  busB;
   logic              issue;
   logic [BANK_W-1:0] ibank;
   logic [ADDR_W-1:0] ird;
   logic              busy_a;
   logic              busy_b;
   logic              stall;

   modport master (
      output write, wbank, rd, busW, rbank_a, rs, rbank_b, rt, issue, ibank, ird,
      input  busA, busB, busy_a, busy_b, stall
   );

   modport slave (
      input  write, wbank, rd, busW, rbank_a, rs, rbank_b, rt, issue, ibank, ird,
      output busA, busB, busy_a, busy_b, stall
   );
endinterface

// File: rtl/banked_regfile_sb.sv
// Multi-bank register file with per-register busy scoreboard and RAW/WAW stall.
// Optional macro REGFILE_BYPASS_EN forwards the write-back value to same-cycle reads.
module banked_regfile_sb #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int BANK_W = 1
) (
   input logic               clk,
   input logic               reset,
   banked_regfile_sb_if.slave bus
);
   localparam int NBANKS = 2 ** BANK_W;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [WIDTH-1:0] r_regs [NBANKS][DEPTH];
   logic [DEPTH-1:0] r_busy [NBANKS];

   logic             w_zeroW;
   logic             w_zeroI;
   logic             w_zeroA;
   logic             w_zeroB;
   logic             w_fwdA;
   logic             w_fwdB;
   logic             w_busyA;
   logic             w_busyB;
   logic             w_waw;
   logic             w_stall;
   logic             w_accept;

   // Bank 0 register 0 is the hardwired zero register
   assign w_zeroW = (bus.wbank == '0) && (bus.rd == '0);
   assign w_zeroI = (bus.ibank == '0) && (bus.ird == '0);
   assign w_zeroA = (bus.rbank_a == '0) && (bus.rs == '0);
   assign w_zeroB = (bus.rbank_b == '0) && (bus.rt == '0);

`ifdef REGFILE_BYPASS_EN
   assign w_fwdA = bus.write && (bus.wbank == bus.rbank_a) && (bus.rd == bus.rs) && !w_zeroA;
   assign w_fwdB = bus.write && (bus.wbank == bus.rbank_b) && (bus.rd == bus.rt) && !w_zeroB;
`else
   assign w_fwdA = 1'b0;
   assign w_fwdB = 1'b0;
`endif

   always_comb begin
      bus.busA = '0;
      bus.busB = '0;
      w_busyA  = 1'b0;
      w_busyB  = 1'b0;
      if (w_fwdA) begin
         bus.busA = bus.busW;
      end else if (!w_zeroA) begin
         bus.busA = r_regs[bus.rbank_a][bus.rs];
         w_busyA  = r_busy[bus.rbank_a][bus.rs];
      end
      if (w_fwdB) begin
         bus.busB = bus.busW;
      end else if (!w_zeroB) begin
         bus.busB = r_regs[bus.rbank_b][bus.rt];
         w_busyB  = r_busy[bus.rbank_b][bus.rt];
      end
   end

   assign w_waw      = bus.issue && !w_zeroI && r_busy[bus.ibank][bus.ird];
   assign w_stall    = w_busyA || w_busyB || w_waw;
   assign w_accept   = bus.issue && !w_stall;
   assign bus.busy_a = w_busyA;
   assign bus.busy_b = w_busyB;
   assign bus.stall  = w_stall;

   // The issue update comes after the write-back clear so a same-cycle issue leaves the register busy
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NBANKS; b++) begin
            r_busy[b] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               r_regs[b][i] <= '0;
            end
         end
      end else begin
         if (bus.write && !w_zeroW) begin
            r_regs[bus.wbank][bus.rd] <= bus.busW;
            r_busy[bus.wbank][bus.rd] <= 1'b0;
         end
         if (w_accept && !w_zeroI) begin
            r_busy[bus.ibank][bus.ird] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_banked_regfile_sb.sv
// Directed table-driven bench for banked_regfile_sb plus hand sequences for
// bypass timing, same-cycle issue/write and mid-sequence reset.
module tb_banked_regfile_sb;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   banked_regfile_sb_if #(.WIDTH(32), .ADDR_W(5), .BANK_W(1)) rfIf ();

   banked_regfile_sb #(.WIDTH(32), .ADDR_W(5), .BANK_W(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (rfIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [0:0]  wb;
      logic [4:0]  wrd;
      logic [31:0] wdata;
      logic [0:0]  ba;
      logic [4:0]  ra;
      logic [0:0]  bb;
      logic [4:0]  rb;
      logic        iss;
      logic [0:0]  ib;
      logic [4:0]  ird;
      logic [31:0] expA;
      logic [31:0] expB;
      logic        expBusyA;
      logic        expBusyB;
      logic        expStall;
   } vec_t;

   vec_t vecs [12];

   task automatic applyStimulus(input vec_t v);
      rfIf.write   = v.wr;
      rfIf.wbank   = v.wb;
      rfIf.rd      = v.wrd;
      rfIf.busW    = v.wdata;
      rfIf.rbank_a = v.ba;
      rfIf.rs      = v.ra;
      rfIf.rbank_b = v.bb;
      rfIf.rt      = v.rb;
      rfIf.issue   = v.iss;
      rfIf.ibank   = v.ib;
      rfIf.ird     = v.ird;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [31:0] eA, input logic [31:0] eB,
                           input logic bA, input logic bB, input logic st);
      checkOutput({tag, ".busA"},   rfIf.busA, eA);
      checkOutput({tag, ".busB"},   rfIf.busB, eB);
      checkOutput({tag, ".busy_a"}, {31'd0, rfIf.busy_a}, {31'd0, bA});
      checkOutput({tag, ".busy_b"}, {31'd0, rfIf.busy_b}, {31'd0, bB});
      checkOutput({tag, ".stall"},  {31'd0, rfIf.stall},  {31'd0, st});
   endtask

   task automatic idleInputs();
      rfIf.write   = 1'b0;
      rfIf.wbank   = 1'b0;
      rfIf.rd      = 5'd0;
      rfIf.busW    = 32'd0;
      rfIf.rbank_a = 1'b0;
      rfIf.rs      = 5'd0;
      rfIf.rbank_b = 1'b0;
      rfIf.rt      = 5'd0;
      rfIf.issue   = 1'b0;
      rfIf.ibank   = 1'b0;
      rfIf.ird     = 5'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      // wr wb wrd wdata | ba ra bb rb | iss ib ird | expA expB bA bB stall
      vecs[0]  = '{1'b0, 1'b0, 5'd0, 32'd0,    1'b0, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 32'd0,    32'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 5'd1, 32'd1,    1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0,    32'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 5'd2, 32'd2,    1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 1'b0, 5'd0, 32'd1,    32'd1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 5'd3, 32'd7,    1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 32'd1,    32'd2, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 5'd3, 32'd5,    1'b1, 5'd3, 1'b0, 5'd2, 1'b0, 1'b0, 5'd0, 32'd7,    32'd2, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 5'd0, 32'd9,    1'b1, 5'd3, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 32'd7,    32'd5, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd4, 32'd0,    32'd5, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'd0,    1'b1, 5'd4, 1'b0, 5'd1, 1'b1, 1'b1, 5'd4, 32'd0,    32'd1, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 5'd0, 32'd0,    32'd1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd4, 32'd0,    32'd0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 5'd0, 32'h11,   1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0,    32'd0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 5'd0, 32'd0,    1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h11,   32'd0, 1'b0, 1'b0, 1'b0};

      idleInputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkAll($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB,
                  vecs[i].expBusyA, vecs[i].expBusyB, vecs[i].expStall);
         tick();
      end

      // Write-back to busy bank1 r4 while both ports read it
      idleInputs();
      rfIf.write   = 1'b1;
      rfIf.wbank   = 1'b1;
      rfIf.rd      = 5'd4;
      rfIf.busW    = 32'hAB;
      rfIf.rbank_a = 1'b1;
      rfIf.rs      = 5'd4;
      rfIf.rbank_b = 1'b1;
      rfIf.rt      = 5'd4;
      #1;
`ifdef REGFILE_BYPASS_EN
      checkAll("bypassSame", 32'hAB, 32'hAB, 1'b0, 1'b0, 1'b0);
`else
      checkAll("bypassSame", 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
`endif
      tick();
      rfIf.write = 1'b0;
      #1;
      checkAll("bypassNext", 32'hAB, 32'hAB, 1'b0, 1'b0, 1'b0);

      // Same-cycle accepted issue and write to bank0 r6: busy wins, data still lands
      idleInputs();
      rfIf.rs    = 5'd7;
      rfIf.rt    = 5'd7;
      rfIf.issue = 1'b1;
      rfIf.ird   = 5'd6;
      rfIf.write = 1'b1;
      rfIf.rd    = 5'd6;
      rfIf.busW  = 32'h66;
      #1;
      checkAll("issueWrite", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      tick();
      idleInputs();
      rfIf.rs = 5'd6;
      rfIf.rt = 5'd7;
      #1;
      checkAll("issueWriteAfter", 32'h66, 32'd0, 1'b1, 1'b0, 1'b1);
      rfIf.write = 1'b1;
      rfIf.rd    = 5'd6;
      rfIf.busW  = 32'h67;
      tick();
      rfIf.write = 1'b0;
      #1;
      checkAll("busyCleared", 32'h67, 32'd0, 1'b0, 1'b0, 1'b0);

      // Mid-sequence reset overrides a concurrent write and issue
      idleInputs();
      rfIf.issue = 1'b1;
      rfIf.ibank = 1'b1;
      rfIf.ird   = 5'd9;
      rfIf.write = 1'b1;
      rfIf.rd    = 5'd10;
      rfIf.busW  = 32'h5;
      tick();
      rfIf.ird   = 5'd12;
      rfIf.ibank = 1'b0;
      rfIf.rd    = 5'd11;
      rfIf.busW  = 32'h3;
      reset      = 1'b1;
      tick();
      reset = 1'b0;
      idleInputs();
      rfIf.rbank_a = 1'b1;
      rfIf.rs      = 5'd9;
      rfIf.rt      = 5'd10;
      #1;
      checkAll("resetA", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      rfIf.rbank_a = 1'b0;
      rfIf.rs      = 5'd11;
      rfIf.rt      = 5'd12;
      #1;
      checkAll("resetB", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      rfIf.rs = 5'd6;
      rfIf.rt = 5'd1;
      #1;
      checkAll("resetC", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
